// File: rtl/cpr_pipe_adder_pkg.sv
// Shared arithmetic helpers for the pipelined carry-save adder: result width,
// compressor-tree row counts and depth, and pipeline stage boundaries.
package cpr_pipe_adder_pkg;

   // Result width: operand width plus growth for NUM_OPS terms plus guard bits.
   function automatic int rw_f(input int width, input int num_ops, input int guard);
      return width + $clog2(num_ops) + guard;
   endfunction

   // Rows left after one full-adder level: each triple becomes sum+carry,
   // leftovers pass through untouched.
   function automatic int next_rows(input int n);
      return 2 * (n / 3) + n % 3;
   endfunction

   // Number of rows entering tree level lvl.
   function automatic int rows_at(input int num_ops, input int lvl);
      int n;
      n = num_ops;
      for (int i = 0; i < lvl; i++) n = next_rows(n);
      return n;
   endfunction

   // Full-adder levels needed to reduce num_ops rows down to two.
   function automatic int tree_depth(input int num_ops);
      int n;
      int d;
      n = num_ops;
      d = 0;
      while (n > 2) begin
         n = next_rows(n);
         d++;
      end
      return d;
   endfunction

   // First tree level handled by stage s (ceil split); s == stages gives depth.
   function automatic int stage_bound(input int depth, input int stages, input int s);
      int per;
      int b;
      per = (depth + stages - 1) / stages;
      b   = s * per;
      if (b > depth) b = depth;
      return b;
   endfunction

endpackage

// File: rtl/cpr_fa.sv
// Single-bit full adder cell (3:2 compressor).
module cpr_fa (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/cpr_pipe_stage.sv
// One level-group of the carry-save tree: levels [LVL_LO, LVL_HI) of full
// adders, followed by an optional register rank carrying valid and acc flag.
module cpr_pipe_stage
   import cpr_pipe_adder_pkg::*;
#(
   parameter int RW      = 27,
   parameter int NUM_OPS = 8,
   parameter int LVL_LO  = 0,
   parameter int LVL_HI  = 2,
   parameter bit REG     = 1'b1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        adv,
   input  logic                        d_valid,
   input  logic                        d_acc,
   input  logic [NUM_OPS-1:0][RW-1:0]  d_rows,
   output logic                        q_valid,
   output logic                        q_acc,
   output logic [NUM_OPS-1:0][RW-1:0]  q_rows
);

   localparam int NL = LVL_HI - LVL_LO;

   logic [NUM_OPS-1:0][RW-1:0] lvl_rows [0:NL];

   assign lvl_rows[0] = d_rows;

   for (genvar j = 0; j < NL; j++) begin : g_lvl
      localparam int N  = rows_at(NUM_OPS, LVL_LO + j);
      localparam int G  = N / 3;
      localparam int NN = next_rows(N);

      for (genvar g = 0; g < G; g++) begin : g_csa
         logic [RW-1:0] s_row;
         logic [RW-1:0] c_row;
         for (genvar k = 0; k < RW; k++) begin : g_bit
            cpr_fa u_fa (
               .a  (lvl_rows[j][3*g][k]),
               .b  (lvl_rows[j][3*g+1][k]),
               .ci (lvl_rows[j][3*g+2][k]),
               .s  (s_row[k]),
               .co (c_row[k])
            );
         end
         // Carry row weighs one column more; the top carry falls off because
         // RW already holds the exact worst-case sum.
         assign lvl_rows[j+1][2*g]   = s_row;
         assign lvl_rows[j+1][2*g+1] = {c_row[RW-2:0], 1'b0};
      end

      for (genvar p = 0; p < N % 3; p++) begin : g_pass
         assign lvl_rows[j+1][2*G+p] = lvl_rows[j][3*G+p];
      end

      for (genvar z = NN; z < NUM_OPS; z++) begin : g_zero
         assign lvl_rows[j+1][z] = '0;
      end
   end

   if (REG) begin : g_reg
      // Valid bit: cleared on reset, moves only when the pipeline advances.
      always_ff @(posedge clk or posedge rst) begin
         if (rst)      q_valid <= 1'b0;
         else if (adv) q_valid <= d_valid;
      end

      // Payload: loaded only from a valid stage so bubbles never disturb it.
      // NOTE: datapath registers carry no reset; they are ignored until the
      // matching valid bit is set, which keeps reset fan-out small.
      always_ff @(posedge clk) begin
         if (adv && d_valid) begin
            q_acc  <= d_acc;
            q_rows <= lvl_rows[NL];
         end
      end
   end else begin : g_comb
      assign q_valid = d_valid;
      assign q_acc   = d_acc;
      assign q_rows  = lvl_rows[NL];
   end

endmodule

// File: rtl/cpr_pipe_adder.sv
// Pipelined multi-operand adder: carry-save compressor tree split into STAGES
// register ranks, a final carry-propagate add, and an accumulating output
// register with valid/ready flow control.
module cpr_pipe_adder
   import cpr_pipe_adder_pkg::*;
#(
   parameter int  WIDTH     = 16,
   parameter int  NUM_OPS   = 8,
   parameter int  STAGES    = 2,
   parameter int  ACC_GUARD = 8,
   localparam int RW        = rw_f(WIDTH, NUM_OPS, ACC_GUARD)
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     in_valid_i,
   output logic                     in_ready_o,
   input  logic [NUM_OPS*WIDTH-1:0] ops_i,
   input  logic                     acc_i,
   output logic                     out_valid_o,
   input  logic                     out_ready_i,
   output logic [RW-1:0]            sum_o,
   output logic                     acc_o
);

   localparam int DEPTH = tree_depth(NUM_OPS);

   logic [NUM_OPS-1:0][RW-1:0] st_rows [0:STAGES];
   logic [STAGES:0]            st_valid;
   logic [STAGES:0]            st_acc;
   logic                       advance;
   logic [RW-1:0]              acc_q;
   logic [RW-1:0]              tree_sum;
   logic [RW-1:0]              next_sum;

   // Every rank moves together whenever the output slot is free or draining.
   assign advance    = !out_valid_o || out_ready_i;
   assign in_ready_o = advance;

   for (genvar k = 0; k < NUM_OPS; k++) begin : g_in
      assign st_rows[0][k] = RW'(ops_i[k*WIDTH +: WIDTH]);
   end
   assign st_valid[0] = in_valid_i;
   assign st_acc[0]   = acc_i;

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      cpr_pipe_stage #(
         .RW      (RW),
         .NUM_OPS (NUM_OPS),
         .LVL_LO  (stage_bound(DEPTH, STAGES, s)),
         .LVL_HI  (stage_bound(DEPTH, STAGES, s + 1)),
         .REG     (1'b1)
      ) u_stage (
         .clk     (clk_i),
         .rst     (rst_i),
         .adv     (advance),
         .d_valid (st_valid[s]),
         .d_acc   (st_acc[s]),
         .d_rows  (st_rows[s]),
         .q_valid (st_valid[s+1]),
         .q_acc   (st_acc[s+1]),
         .q_rows  (st_rows[s+1])
      );
   end

   // Final carry-propagate add and optional accumulate; wraps silently mod 2^RW.
   assign tree_sum = st_rows[STAGES][0] + st_rows[STAGES][1];
   assign next_sum = st_acc[STAGES] ? acc_q + tree_sum : tree_sum;

   // Output register and accumulator: update only on a valid transaction.
   // NOTE: non-blocking assignments so acc_q read by next_sum is always the
   // pre-edge value, giving hazard-free back-to-back accumulation.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_valid_o <= 1'b0;
         sum_o       <= '0;
         acc_o       <= 1'b0;
         acc_q       <= '0;
      end else if (advance) begin
         out_valid_o <= st_valid[STAGES];
         if (st_valid[STAGES]) begin
            sum_o <= next_sum;
            acc_o <= st_acc[STAGES];
            acc_q <= next_sum;
         end
      end
   end

endmodule

// File: tb/tb_cpr_pipe_adder.sv
// Self-checking bench for cpr_pipe_adder: directed scenarios plus random
// traffic, all compared against an in-order arithmetic reference model.
module tb_cpr_pipe_adder;

   localparam int WIDTH     = 16;
   localparam int NUM_OPS   = 8;
   localparam int STAGES    = 2;
   localparam int ACC_GUARD = 8;
   localparam int RW        = WIDTH + $clog2(NUM_OPS) + ACC_GUARD;
   localparam int OPW       = NUM_OPS * WIDTH;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [OPW-1:0] ops;
   logic           acc;
   logic           out_valid;
   logic           out_ready;
   logic [RW-1:0]  sum_o;
   logic           acc_o;

   cpr_pipe_adder #(
      .WIDTH     (WIDTH),
      .NUM_OPS   (NUM_OPS),
      .STAGES    (STAGES),
      .ACC_GUARD (ACC_GUARD)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .ops_i       (ops),
      .acc_i       (acc),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .sum_o       (sum_o),
      .acc_o       (acc_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [RW-1:0] sum;
      logic          acc;
      int            issued;
   } exp_t;

   exp_t          exp_q[$];
   logic [RW-1:0] model_acc;
   int            cyc;
   int            total;
   int            bad;
   int            pops;
   int            last_lat;
   logic [RW-1:0] last_sum;
   logic [RW-1:0] pop_sums[$];
   int            pop_cycles[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   function automatic logic [OPW-1:0] fill(input logic [WIDTH-1:0] v);
      logic [OPW-1:0] r;
      for (int k = 0; k < NUM_OPS; k++) r[k*WIDTH +: WIDTH] = v;
      return r;
   endfunction

   // Reference: plain integer sum of the operands, optionally added onto the
   // previous result in issue order, reduced mod 2^RW.
   task automatic model_push();
      longint s;
      exp_t   e;
      s = 0;
      for (int k = 0; k < NUM_OPS; k++) s += longint'(ops[k*WIDTH +: WIDTH]);
      if (acc) model_acc = model_acc + RW'(s);
      else     model_acc = RW'(s);
      e.sum    = model_acc;
      e.acc    = acc;
      e.issued = cyc;
      exp_q.push_back(e);
   endtask

   // One clock cycle: inputs are already set at the falling edge; observe the
   // handshakes that will happen at the next rising edge.
   task automatic tick();
      #1;
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", 64'(out_valid), 64'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("sum", 64'(sum_o), 64'(e.sum));
            check("acc_flag", 64'(acc_o), 64'(e.acc));
            last_lat = cyc - e.issued;
            last_sum = sum_o;
            pop_sums.push_back(sum_o);
            pop_cycles.push_back(cyc);
            pops++;
         end
      end
      if (in_valid && in_ready && !rst) model_push();
      @(negedge clk);
      cyc++;
   endtask

   task automatic send(input logic [OPW-1:0] v, input logic a);
      in_valid = 1'b1;
      ops      = v;
      acc      = a;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int i = 0; i < 60 && exp_q.size() > 0; i++) tick();
      check("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic clear_log();
      pop_sums.delete();
      pop_cycles.delete();
   endtask

   initial begin
      int             p0;
      logic [OPW-1:0] v;

      total = 0; bad = 0; pops = 0; cyc = 0; last_lat = 0; last_sum = '0;
      model_acc = '0;
      rst = 1'b1; in_valid = 1'b0; ops = '0; acc = 1'b0; out_ready = 1'b1;

      // Reset state.
      #2;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_sum", 64'(sum_o), 64'd0);
      check("rst_acc_o", 64'(acc_o), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("ready_after_rst", 64'(in_ready), 64'd1);

      // Operands 1..8, plain sum, latency of three cycles.
      for (int k = 0; k < NUM_OPS; k++) v[k*WIDTH +: WIDTH] = WIDTH'(k + 1);
      clear_log();
      send(v, 1'b0);
      drain();
      check("ops_1to8_sum", 64'(last_sum), 64'd36);
      check("ops_1to8_latency", 64'(last_lat), 64'd3);

      // Worst case, all operands at maximum.
      send(fill('1), 1'b0);
      drain();
      check("all_ones_sum", 64'(last_sum), 64'h7FFF8);

      // Back-to-back accumulation of all-ones sets.
      clear_log();
      send(fill(16'd1), 1'b0);
      send(fill(16'd1), 1'b1);
      send(fill(16'd1), 1'b1);
      send(fill(16'd1), 1'b1);
      drain();
      check("b2b_count", 64'(pop_sums.size()), 64'd4);
      if (pop_sums.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            check("b2b_sum", 64'(pop_sums[i]), 64'(8 * (i + 1)));
            check("b2b_consecutive", 64'(pop_cycles[i] - pop_cycles[0]), 64'(i));
         end
      end

      // Output stall with three sets in flight.
      clear_log();
      out_ready = 1'b0;
      send(fill(16'd3), 1'b0);
      send(fill(16'd5), 1'b0);
      send(fill(16'd7), 1'b0);
      for (int i = 0; i < 5; i++) begin
         #1;
         check("stall_out_valid", 64'(out_valid), 64'd1);
         check("stall_in_ready", 64'(in_ready), 64'd0);
         check("stall_sum_stable", 64'(sum_o), 64'd24);
         tick();
      end
      drain();
      check("stall_count", 64'(pop_sums.size()), 64'd3);
      if (pop_sums.size() == 3) begin
         check("stall_order0", 64'(pop_sums[0]), 64'd24);
         check("stall_order1", 64'(pop_sums[1]), 64'd40);
         check("stall_order2", 64'(pop_sums[2]), 64'd56);
      end

      // Accumulator wrap: 256 x 0x7FFF8 + 2044 = 2^RW-4, then add 10.
      clear_log();
      in_valid = 1'b1;
      for (int i = 0; i < 256; i++) begin
         ops = fill('1);
         acc = (i != 0);
         tick();
      end
      ops = '0; ops[WIDTH-1:0] = 16'd2044; acc = 1'b1;
      tick();
      for (int k = 0; k < NUM_OPS; k++) ops[k*WIDTH +: WIDTH] = (k < 4) ? WIDTH'(k + 1) : '0;
      tick();
      in_valid = 1'b0;
      drain();
      check("wrap_count", 64'(pop_sums.size()), 64'd258);
      if (pop_sums.size() == 258) begin
         check("wrap_pre", 64'(pop_sums[256]), 64'((64'd1 << RW) - 4));
         check("wrap_sum", 64'(pop_sums[257]), 64'd6);
      end

      // Reset with two transactions in flight.
      out_ready = 1'b0;
      send(fill(16'd2), 1'b0);
      send(fill(16'd2), 1'b1);
      tick();
      rst = 1'b1;
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_in_ready", 64'(in_ready), 64'd1);
      exp_q.delete();
      model_acc = '0;
      out_ready = 1'b1;
      tick();
      rst = 1'b0;
      p0 = pops;
      for (int i = 0; i < 6; i++) tick();
      check("midrst_no_result", 64'(pops - p0), 64'd0);
      send(fill(16'd1), 1'b1);
      drain();
      check("midrst_acc_from_zero", 64'(last_sum), 64'd8);

      // Random traffic with random back-pressure.
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(3) != 0);
         acc       = $urandom_range(1);
         if ($urandom_range(7) == 0) ops = fill('1);
         else for (int k = 0; k < NUM_OPS; k++) ops[k*WIDTH +: WIDTH] = WIDTH'($urandom);
         tick();
      end
      in_valid = 1'b0;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
